// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: execute-to-writeback stage; registers ALU results onto the register-file write port.
// Ports: clk/rst (sync, active-high); in_valid/in_ready handshake; alu_result (2N), alu_flags {N,Z,C,V},
// alu_sel, rd, reg_write, set_flags from the ALU; wb_en/wb_addr/wb_data register-file write port;
// flags_q architectural flags; branch_taken one-cycle BNE pulse; busy while not IDLE.
// Optional MUL_HI_WB_EN: a writing MUL also writes product[2N-1:N] to rd+1 in a second (HI) cycle.
module alu_writeback_stage #(
    parameter int N          = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*N-1:0]        alu_result,
    input  logic [3:0]            alu_flags,
    input  logic [2:0]            alu_sel,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  set_flags,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [N-1:0]          wb_data,
    output logic [3:0]            flags_q,
    output logic                  branch_taken,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, LO, HI} state_t;
    localparam logic [2:0] SEL_MUL = 3'b100;
    localparam logic [2:0] SEL_BNE = 3'b110;
    state_t     state;
    logic [3:0] h_flags;
    logic       h_sf_ok;
    logic       xfer;
    logic       hi_pending;
    logic       arch_op;
    // BNE (110) and no-op (111) never write registers or flags
    assign arch_op = alu_sel < SEL_BNE;
`ifdef MUL_HI_WB_EN
    localparam logic [REG_ADDR_W-1:0] ONE = 1;
    logic [REG_ADDR_W-1:0] h_rd;
    logic [N-1:0]          h_hi;
    logic                  h_mulw;
    assign hi_pending = state == LO && h_mulw;
`else
    logic unused_hi;
    assign unused_hi  = ^alu_result[2*N-1:N];
    assign hi_pending = 1'b0;
`endif
    assign in_ready = !rst && !hi_pending;
    assign xfer     = in_valid && in_ready;
    assign busy     = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wb_en        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            flags_q      <= 4'b0000;
            branch_taken <= 1'b0;
            h_sf_ok      <= 1'b0;
        end else begin
            if (state == LO && h_sf_ok)
                flags_q <= h_flags;
            if (xfer) begin
                state        <= LO;
                h_flags      <= alu_flags;
                h_sf_ok      <= set_flags && arch_op;
`ifdef MUL_HI_WB_EN
                h_rd         <= rd;
                h_hi         <= alu_result[2*N-1:N];
                h_mulw       <= alu_sel == SEL_MUL && reg_write;
`endif
                wb_en        <= reg_write && arch_op;
                wb_addr      <= rd;
                wb_data      <= alu_result[N-1:0];
                branch_taken <= alu_sel == SEL_BNE && !alu_flags[2];
`ifdef MUL_HI_WB_EN
            end else if (hi_pending) begin
                state        <= HI;
                h_sf_ok      <= 1'b0;
                wb_en        <= 1'b1;
                wb_addr      <= h_rd + ONE;
                wb_data      <= h_hi;
                branch_taken <= 1'b0;
`endif
            end else begin
                state        <= IDLE;
                h_sf_ok      <= 1'b0;
                wb_en        <= 1'b0;
                branch_taken <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_writeback_stage.sv
// tb_alu_writeback_stage: directed and randomized checks of alu_writeback_stage against an event-schedule model.
module tb_alu_writeback_stage;
`ifdef MUL_HI_WB_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] alu_result = '0;
    logic [3:0]  alu_flags = '0;
    logic [2:0]  alu_sel = 3'b111;
    logic [3:0]  rd = '0;
    logic        reg_write = 1'b0;
    logic        set_flags = 1'b0;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  flags_q;
    logic        branch_taken;
    logic        busy;
    int n_tests = 0;
    int n_fail  = 0;
    // model: what the outputs should show, plus events already scheduled for the next edge
    logic        m_en = 0, m_bt = 0, m_busy = 0;
    logic [3:0]  m_addr = 0, m_flags = 0;
    logic [15:0] m_data = 0;
    logic        m_hi = 0, m_fp = 0;
    logic [3:0]  m_hd = 0, m_fv = 0;
    logic [15:0] m_hdata = 0;
    logic        obs_ready, exp_ready;
    wire  [26:0] outs = {wb_en, wb_addr, wb_data, branch_taken, flags_q, busy};
    wire  [26:0] exp_outs = {m_en, m_addr, m_data, m_bt, m_flags, m_busy};
    alu_writeback_stage #(.N(16), .REG_ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .alu_flags(alu_flags), .alu_sel(alu_sel), .rd(rd),
        .reg_write(reg_write), .set_flags(set_flags), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .flags_q(flags_q), .branch_taken(branch_taken), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic step(input logic v, input logic [2:0] s, input logic [31:0] res, input logic [3:0] f,
                        input logic [3:0] d, input logic w, input logic sf, input logic r);
        logic writes;
        in_valid = v; alu_sel = s; alu_result = res; alu_flags = f; rd = d;
        reg_write = w; set_flags = sf; rst = r;
        #1;
        obs_ready = in_ready;
        exp_ready = !r && !m_hi;
        @(posedge clk);
        if (r) begin
            {m_en, m_addr, m_data, m_bt, m_flags, m_busy, m_hi, m_fp} = '0;
        end else begin
            if (m_fp) m_flags = m_fv;
            m_fp = 1'b0;
            if (v && exp_ready) begin
                writes  = !(s == 3'b110 || s == 3'b111);
                m_en    = w && writes;
                m_addr  = d;
                m_data  = res[15:0];
                m_bt    = s == 3'b110 && !f[2];
                m_busy  = 1'b1;
                m_fp    = sf && writes;
                m_fv    = f;
                m_hi    = HI_EN && s == 3'b100 && w;
                m_hd    = d + 4'd1;
                m_hdata = res[31:16];
            end else if (m_hi) begin
                {m_en, m_addr, m_data, m_bt, m_busy} = {1'b1, m_hd, m_hdata, 1'b0, 1'b1};
                m_hi = 1'b0;
            end else begin
                {m_en, m_bt, m_busy} = 3'b000;
            end
        end
        #1;
    endtask
    task automatic idle();
        step(1'b0, 3'b111, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic test_reset();
        step(1'b1, 3'b000, $urandom, 4'hF, 4'h7, 1'b1, 1'b1, 1'b1);
        step(1'b1, 3'b100, $urandom, 4'hF, 4'h7, 1'b1, 1'b1, 1'b1);
        n_tests++;
        if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b want=0", obs_ready); end
        n_tests++;
        if (outs !== 27'h0) begin n_fail++; $display("FAIL reset_outs got=%h want=%h", outs, 27'h0); end
        idle();
        n_tests++;
        if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset got=%b want=1", obs_ready); end
    endtask
    task automatic test_add();
        step(1'b1, 3'b000, 32'h0000_1234, 4'h0, 4'd3, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({wb_en, wb_addr, wb_data, branch_taken} !== {1'b1, 4'd3, 16'h1234, 1'b0}) begin
            n_fail++; $display("FAIL add_lo got=%b/%0d/%h/%b want=1/3/1234/0", wb_en, wb_addr, wb_data, branch_taken);
        end
        idle();
        n_tests++;
        if ({obs_ready, flags_q, wb_en} !== {1'b1, 4'b0000, 1'b0}) begin
            n_fail++; $display("FAIL add_after got ready=%b flags=%b en=%b want 1/0000/0", obs_ready, flags_q, wb_en);
        end
    endtask
    task automatic test_mul();
        step(1'b1, 3'b100, 32'h0002_0003, 4'h0, 4'd15, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if ({wb_en, wb_addr, wb_data} !== {1'b1, 4'd15, 16'h0003}) begin
            n_fail++; $display("FAIL mul_lo got=%b/%0d/%h want=1/15/0003", wb_en, wb_addr, wb_data);
        end
        idle();
        n_tests++;
        if (obs_ready !== !HI_EN) begin n_fail++; $display("FAIL mul_lo_ready got=%b want=%b", obs_ready, !HI_EN); end
        n_tests++;
        if (HI_EN && {wb_en, wb_addr, wb_data, busy} !== {1'b1, 4'd0, 16'h0002, 1'b1}) begin
            n_fail++; $display("FAIL mul_hi got=%b/%0d/%h/%b want=1/0/0002/1", wb_en, wb_addr, wb_data, busy);
        end else if (!HI_EN && {wb_en, busy} !== 2'b00) begin
            n_fail++; $display("FAIL mul_no_hi got en=%b busy=%b want 0/0", wb_en, busy);
        end
        idle();
        n_tests++;
        if ({wb_en, busy} !== 2'b00) begin n_fail++; $display("FAIL mul_done got en=%b busy=%b want 0/0", wb_en, busy); end
    endtask
    task automatic test_bne();
        logic [3:0] f0;
        f0 = m_flags;
        step(1'b1, 3'b110, $urandom, 4'b0000, 4'd5, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({branch_taken, wb_en} !== 2'b10) begin
            n_fail++; $display("FAIL bne_taken got bt=%b en=%b want 1/0", branch_taken, wb_en);
        end
        idle();
        n_tests++;
        if ({branch_taken, flags_q} !== {1'b0, f0}) begin
            n_fail++; $display("FAIL bne_pulse got bt=%b flags=%b want 0/%b", branch_taken, flags_q, f0);
        end
        step(1'b1, 3'b110, $urandom, 4'b0100, 4'd5, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({branch_taken, wb_en} !== 2'b00) begin
            n_fail++; $display("FAIL bne_not_taken got bt=%b en=%b want 0/0", branch_taken, wb_en);
        end
        idle();
        n_tests++;
        if (flags_q !== f0) begin n_fail++; $display("FAIL bne_flags got=%b want=%b", flags_q, f0); end
    endtask
    task automatic test_back_to_back();
        logic [2:0]  sels [3] = '{3'b001, 3'b010, 3'b101};
        logic [15:0] data [3] = '{16'hA1A1, 16'h0F0F, 16'hBEEF};
        for (int i = 0; i < 3; i++) begin
            step(1'b1, sels[i], {16'h0, data[i]}, 4'h0, 4'(i + 8), 1'b1, 1'b0, 1'b0);
            n_tests++;
            if ({obs_ready, wb_en, wb_addr, wb_data} !== {1'b1, 1'b1, 4'(i + 8), data[i]}) begin
                n_fail++; $display("FAIL b2b_%0d got rdy=%b en=%b addr=%0d data=%h want 1/1/%0d/%h",
                                   i, obs_ready, wb_en, wb_addr, wb_data, i + 8, data[i]);
            end
        end
        idle();
    endtask
    task automatic test_reset_mid();
        step(1'b1, 3'b100, 32'h1234_5678, 4'hF, 4'd6, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'b111, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (outs !== 27'h0) begin n_fail++; $display("FAIL reset_mid got=%h want=%h", outs, 27'h0); end
        idle();
        n_tests++;
        if ({wb_en, busy, flags_q} !== 6'b0) begin
            n_fail++; $display("FAIL reset_mid_no_hi got en=%b busy=%b flags=%b want 0/0/0000", wb_en, busy, flags_q);
        end
    endtask
    task automatic test_flags_noop();
        step(1'b1, 3'b001, 32'h0000_8000, 4'b1000, 4'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 3'b111, 32'h0000_0001, 4'b0001, 4'd2, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if ({flags_q, wb_en} !== {4'b1000, 1'b0}) begin
            n_fail++; $display("FAIL noop_lo got flags=%b en=%b want 1000/0", flags_q, wb_en);
        end
        idle();
        idle();
        n_tests++;
        if (flags_q !== 4'b1000) begin n_fail++; $display("FAIL noop_flags got=%b want=1000", flags_q); end
    endtask
    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(($urandom % 4) != 0, 3'($urandom), $urandom, 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), ($urandom % 40) == 0);
            n_tests++;
            if ({obs_ready, outs} !== {exp_ready, exp_outs}) begin
                n_fail++; $display("FAIL random_%0d got rdy=%b outs=%h want rdy=%b outs=%h",
                                   i, obs_ready, outs, exp_ready, exp_outs);
            end
        end
    endtask
    initial begin
        test_reset();
        test_add();
        test_mul();
        test_bne();
        test_back_to_back();
        test_reset_mid();
        test_flags_noop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_writeback_stage.md
# alu_writeback_stage

Execute-to-writeback pipeline stage directly downstream of the 16-bit ALU. Captures the ALU result, NZCV flags and operation select under a valid/ready handshake. Drives the register-file write port, holds the architectural flags register and resolves BNE into a one-cycle branch-taken pulse. A 2N-bit MUL product is written back as two N-bit writes over two cycles.

## Interface
- N, default 16: datapath width; ALU result input is 2N bits.
- REG_ADDR_W, default 4: register-file address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  ALU output valid.
- in_ready  out  1  stage can accept this cycle.
- alu_result  in  2N  ALU result; low N bits for all ops except MUL.
- alu_flags  in  4  {N,Z,C,V} from the ALU.
- alu_sel  in  3  ALU op code: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101 MOV, 110 BNE, 111 no-op.
- rd  in  REG_ADDR_W  destination register.
- reg_write  in  1  op writes the register file.
- set_flags  in  1  op updates flags_q.
- wb_en  out  1  register-file write enable.
- wb_addr  out  REG_ADDR_W  write address.
- wb_data  out  N  write data.
- flags_q  out  4  architectural {N,Z,C,V}.
- branch_taken  out  1  one-cycle pulse, BNE with Z=0.
- busy  out  1  state is not IDLE.

## Operation
- Handshake: transfer occurs on a rising edge where in_valid && in_ready. All inputs are captured into a hold register on that edge.
- State machine:
  - IDLE -> LO on transfer.
  - LO -> HI when the held op is MUL with reg_write=1 and MUL_HI_WB_EN is defined.
  - LO -> LO on a new transfer.
  - LO -> IDLE otherwise.
  - HI -> LO on a new transfer; HI -> IDLE otherwise.
- in_ready = !rst && (IDLE || HI || (LO && no HI phase pending)).
- LO cycle:
  - wb_en = held reg_write && held alu_sel != 110 && != 111.
  - wb_addr = held rd; wb_data = held alu_result[N-1:0].
  - branch_taken = (held alu_sel == 110) && !held Z.
- HI cycle: wb_en=1, wb_addr = held rd+1 modulo 2^REG_ADDR_W (wraps 1111 -> 0000), wb_data = held alu_result[2N-1:N].
- flags_q loads held alu_flags at the end of the LO cycle when held set_flags=1 and alu_sel is not 110 or 111. It is unchanged otherwise and never touched in HI.
- BNE never writes the register file and never updates flags_q, regardless of reg_write/set_flags.
- In IDLE: wb_en=0, branch_taken=0. wb_addr/wb_data hold their last values.
- All outputs except in_ready are driven from registers; there is no combinational path from inputs to wb_*, flags_q or branch_taken.

## Timing
- Latency: transfer on edge T, LO outputs valid in cycle T+1, HI in T+2.
- Throughput: one op per cycle for non-MUL ops. A writing MUL costs 2 cycles with the macro defined; in_ready=0 during its LO cycle.
- A transfer in the LO cycle of a non-MUL op is legal: back-to-back LO cycles with no bubble.
- A transfer in HI is legal: next cycle is LO of the new op.
- Reset values: wb_en=0, wb_addr=0, wb_data=0, flags_q=0000, branch_taken=0, busy=0. in_ready=0 while rst=1, and 1 in the first cycle after reset.
- Reset mid-operation: rst during LO or HI abandons the held op. The next cycle is IDLE with reset values, no HI write is issued and flags_q is not updated. in_valid is ignored while rst=1.

## Configuration
- MUL_HI_WB_EN defined: a writing MUL produces a LO write (rd, product[N-1:0]) followed by a HI write (rd+1, product[2N-1:N]).
- MUL_HI_WB_EN undefined: MUL completes in LO only; alu_result[2N-1:N] is ignored and the HI state is never entered (it may be optimised away).

## Test plan
- Reset, then ADD result 0x0000_1234, rd=3, reg_write=1, set_flags=1, flags 0000 -> cycle T+1: wb_en=1, wb_addr=3, wb_data=0x1234; flags_q=0000 after that cycle; in_ready stays 1.
- MUL product 0x0002_0003, rd=15, macro defined -> T+1: (15, 0x0003), in_ready=0; T+2: (0, 0x0002). Macro undefined -> only (15, 0x0003), T+2 idle.
- BNE with flags 0000, reg_write=1 -> branch_taken=1 for exactly one cycle, wb_en=0, flags_q unchanged. With Z=1 -> branch_taken=0.
- Three back-to-back ops with in_valid held high (SUB, AND, MOV) -> three consecutive wb_en=1 cycles with matching data; no bubbles.
- rst asserted during the LO cycle of a writing MUL -> no HI write, all outputs at reset values the next cycle, flags_q=0000.
- SUB with set_flags=1, flags 1000, then no-op alu_sel=111 with set_flags=1 -> flags_q=1000 and stays 1000; wb_en=0 for the no-op.
